// File: rtl/roi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// roi_frame_ctrl
//
// Purpose: frame-aligns a raw AXI-Stream video input for the ROI datapath.
// It waits for a start-of-frame beat (tuser), then forwards exactly
// IMAGE_WIDTH x IMAGE_HEIGHT pixels through a one-stage register slice.
// On the output, tuser/tlast are regenerated from internal x/y counters.
// It also latches the ROI corner coordinates at each frame start and
// records stream framing errors.
//
// Ports:
//   aclk, aresetn       clock, asynchronous active-low reset
//   enable              frame acceptance permitted (checked at frame boundaries)
//   cfg_coords, cfg_wr  ROI corners {P4_Y,P4_X,..,P1_Y,P1_X} + capture strobe
//   s_axis_*            raw video in (slave)
//   m_axis_*            regenerated video out (master)
//   roi_coords          active coordinates, constant for a whole frame
//   frame_start         1-cycle pulse after the SOF beat is accepted
//   frame_done          1-cycle pulse after the last pixel is accepted
//   err_flags           sticky: [0] early SOF, [1] tlast mismatch
//   err_clr             clears err_flags (and error counters when present)
//
// Optional feature (macro ROI_CTRL_ERR_CNT_EN): adds the saturating 16-bit
// error counters err_sof_cnt and err_last_cnt.
// -----------------------------------------------------------------------------
module roi_frame_ctrl #(
  parameter int IMAGE_WIDTH      = 640,
  parameter int IMAGE_HEIGHT     = 480,
  parameter int AXIS_TDATA_WIDTH = 24,
  parameter int COORD_W          = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [8*COORD_W-1:0]        cfg_coords,
  input  logic                        cfg_wr,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tuser,
  input  logic                        s_axis_tlast,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic [8*COORD_W-1:0]        roi_coords,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic [1:0]                  err_flags,
  input  logic                        err_clr
`ifdef ROI_CTRL_ERR_CNT_EN
  ,
  output logic [15:0]                 err_sof_cnt,
  output logic [15:0]                 err_last_cnt
`endif
);

  localparam int XW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

  state_t                        r_state, w_state_next;
  logic [XW-1:0]                 r_x, w_px_x;
  logic [YW-1:0]                 r_y, w_px_y;
  logic [AXIS_TDATA_WIDTH-1:0]   r_m_tdata;
  logic                          r_m_tvalid, r_m_tuser, r_m_tlast;
  logic [8*COORD_W-1:0]          r_shadow, r_roi;
  logic                          r_pend;
  logic                          r_frame_start, r_frame_done;
  logic [1:0]                    r_err;

  logic w_slice_ready, w_s_ready, w_acc, w_fwd, w_sof, w_early_sof;
  logic w_x_end, w_y_end, w_last_px, w_tlast_err;

  assign w_slice_ready = !r_m_tvalid || m_axis_tready;

  // In WAIT_SOF non-SOF beats are swallowed unconditionally; only the SOF
  // beat has to wait for room in the slice.
  always_comb begin
    w_s_ready = 1'b0;
    case (r_state)
      WAIT_SOF: w_s_ready = s_axis_tuser ? w_slice_ready : 1'b1;
      ACTIVE:   w_s_ready = w_slice_ready;
      default:  w_s_ready = 1'b0;
    endcase
  end

  assign w_acc       = s_axis_tvalid && w_s_ready;
  assign w_fwd       = w_acc && ((r_state == ACTIVE) || (r_state == WAIT_SOF && s_axis_tuser));
  // Any forwarded tuser beat becomes pixel (0,0): normal SOF or early restart.
  assign w_sof       = w_fwd && s_axis_tuser;
  assign w_early_sof = w_acc && (r_state == ACTIVE) && s_axis_tuser && ((r_x != '0) || (r_y != '0));

  // Position of the beat being accepted this cycle.
  assign w_px_x    = w_sof ? '0 : r_x;
  assign w_px_y    = w_sof ? '0 : r_y;
  assign w_x_end   = (w_px_x == XW'(IMAGE_WIDTH - 1));
  assign w_y_end   = (w_px_y == YW'(IMAGE_HEIGHT - 1));
  assign w_last_px = w_fwd && w_x_end && w_y_end;
  assign w_tlast_err = w_fwd && (s_axis_tlast != w_x_end);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (enable) w_state_next = WAIT_SOF;
      WAIT_SOF: begin
        if (w_sof)        w_state_next = ACTIVE;
        else if (!enable) w_state_next = IDLE;
      end
      ACTIVE:   if (w_last_px) w_state_next = enable ? WAIT_SOF : IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_fwd) begin
        if (w_x_end) begin
          r_x <= '0;
          r_y <= w_y_end ? '0 : w_px_y + 1'b1;
        end else begin
          r_x <= w_px_x + 1'b1;
          r_y <= w_px_y;
        end
      end
    end
  end

  // Output register slice; valid only falls when the consumer takes the beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tuser  <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (w_fwd) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s_axis_tdata;
      r_m_tuser  <= (w_px_x == '0) && (w_px_y == '0);
      r_m_tlast  <= w_x_end;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Shadow/active coordinates. A cfg_wr coinciding with the SOF beat goes
  // straight into the active register so that frame uses it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_shadow <= '0;
      r_roi    <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (cfg_wr) r_shadow <= cfg_coords;
      if (w_sof) begin
        r_pend <= 1'b0;
        if (cfg_wr)      r_roi <= cfg_coords;
        else if (r_pend) r_roi <= r_shadow;
      end else if (cfg_wr) begin
        r_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err         <= 2'b00;
    end else begin
      r_frame_start <= w_sof;
      r_frame_done  <= w_last_px;
      // Clear first, then set: a new error wins over err_clr.
      r_err <= (err_clr ? 2'b00 : r_err) | {w_tlast_err, w_early_sof};
    end
  end

`ifdef ROI_CTRL_ERR_CNT_EN
  logic [15:0] r_sof_cnt, r_last_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sof_cnt  <= '0;
      r_last_cnt <= '0;
    end else begin
      if (err_clr)                                r_sof_cnt <= {15'd0, w_early_sof};
      else if (w_early_sof && r_sof_cnt != 16'hFFFF) r_sof_cnt <= r_sof_cnt + 1'b1;
      if (err_clr)                                r_last_cnt <= {15'd0, w_tlast_err};
      else if (w_tlast_err && r_last_cnt != 16'hFFFF) r_last_cnt <= r_last_cnt + 1'b1;
    end
  end

  assign err_sof_cnt  = r_sof_cnt;
  assign err_last_cnt = r_last_cnt;
`endif

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tlast  = r_m_tlast;
  assign roi_coords    = r_roi;
  assign frame_start   = r_frame_start;
  assign frame_done    = r_frame_done;
  assign err_flags     = r_err;

endmodule

// File: tb/tb_roi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_roi_frame_ctrl
//
// Self-checking bench for roi_frame_ctrl with an 8x4 image. A small pixel
// position model predicts every forwarded beat (data, tuser, tlast) and
// pushes it to a scoreboard queue; a monitor pops and compares on each
// output handshake. Frame pulses, error flags and ROI coordinates are
// checked per scenario.
// -----------------------------------------------------------------------------
module tb_roi_frame_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 24;
  localparam int CW = 10;

  logic            clk = 1'b0;
  logic            aresetn = 1'b0;
  logic            enable = 1'b0;
  logic [8*CW-1:0] cfg_coords = '0;
  logic            cfg_wr = 1'b0;
  logic [DW-1:0]   s_tdata = '0;
  logic            s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic            s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tuser, m_tlast;
  logic            m_tready = 1'b1;
  logic [8*CW-1:0] roi_coords;
  logic            frame_start, frame_done;
  logic [1:0]      err_flags;
  logic            err_clr = 1'b0;

  roi_frame_ctrl #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .AXIS_TDATA_WIDTH(DW), .COORD_W(CW)
  ) dut (
    .aclk(clk), .aresetn(aresetn), .enable(enable),
    .cfg_coords(cfg_coords), .cfg_wr(cfg_wr),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .roi_coords(roi_coords), .frame_start(frame_start), .frame_done(frame_done),
    .err_flags(err_flags), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- cycle counter, monitor, back-pressure ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW+1:0] q[$];     // {data, tuser, tlast}
  int n_out = 0, n_fs = 0, n_fd = 0, fd_cyc = 0;
  logic [8*CW-1:0] roi_at_fs = '0;

  // Sampled mid-cycle: a handshake seen here completes on the next posedge.
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (frame_start) begin
      n_fs++;
      roi_at_fs = roi_coords;
    end
    if (frame_done) begin
      n_fd++;
      fd_cyc = cyc;
    end
    if (m_tvalid && m_tready) begin
      n_out++;
      if (q.size() == 0) begin
        check("unexpected_beat", {127'd0, 1'b1}, 128'd0);
      end else begin
        e = q.pop_front();
        check("beat_data", m_tdata, e[DW+1:2]);
        check("beat_tuser", m_tuser, e[1]);
        check("beat_tlast", m_tlast, e[0]);
      end
    end
  end

  logic bp_on = 1'b0;
  always begin
    @(posedge clk);
    #1;
    m_tready = bp_on ? ~m_tready : 1'b1;
  end

  // ---------------- reference position model ----------------
  logic mdl_wait = 1'b1;
  int   mx = 0, my = 0, exp_fs = 0, exp_fd = 0, exp_out = 0, exp_fd_cyc = 0;

  task automatic mdl_accept(input logic [DW-1:0] d, input logic u);
    int px, py;
    if (mdl_wait) begin
      if (!u) return;
      mdl_wait = 1'b0;
    end
    if (u) begin
      px = 0; py = 0; exp_fs++;
    end else begin
      px = mx; py = my;
    end
    q.push_back({d, (px == 0 && py == 0), (px == W - 1)});
    exp_out++;
    if (px == W - 1) begin
      mx = 0;
      if (py == H - 1) begin
        my = 0; mdl_wait = 1'b1; exp_fd++; exp_fd_cyc = cyc + 1;
      end else begin
        my = py + 1;
      end
    end else begin
      mx = px + 1; my = py;
    end
  endtask

  // ---------------- drivers (called at posedge + 1) ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
    bit acc = 0;
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    for (int w = 0; w < 200 && !acc; w++) begin
      @(negedge clk);
      if (s_tready) begin
        acc = 1;
        mdl_accept(d, u);
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 128'd0, 128'd1);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  logic [8*CW-1:0] coords_a, coords_b;

  // nb beats; restart_at: beat carrying an early tuser; bad_last_at: beat
  // with wrong tlast (err_clr held during it); cfg_at: cfg_wr of coords_b
  // after that beat; en_off_at: enable dropped after that beat.
  task automatic send_frame(input int nb, input int restart_at, input int bad_last_at,
                            input int cfg_at, input int en_off_at);
    int pos;
    logic u, l;
    for (int k = 0; k < nb; k++) begin
      pos = (restart_at >= 0 && k >= restart_at) ? k - restart_at : k;
      u = (pos == 0);
      l = ((pos % W) == W - 1) ^ (k == bad_last_at);
      if (k == bad_last_at) err_clr = 1'b1;
      send_beat(24'($urandom), u, l);
      err_clr = 1'b0;
      if (k == cfg_at) begin
        cfg_coords = coords_b; cfg_wr = 1'b1;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        check("roi_hold_mid", roi_coords, coords_a);
      end
      if (k == en_off_at) enable = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
    check("out_count", n_out, exp_out);
    check("fs_count", n_fs, exp_fs);
    check("fd_count", n_fd, exp_fd);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tvalid"}, m_tvalid, 0);
    check({tag, "_tdata"},  m_tdata, 0);
    check({tag, "_tuser"},  m_tuser, 0);
    check({tag, "_tlast"},  m_tlast, 0);
    check({tag, "_tready"}, s_tready, 0);
    check({tag, "_roi"},    roi_coords, 0);
    check({tag, "_fs"},     frame_start, 0);
    check({tag, "_fd"},     frame_done, 0);
    check({tag, "_err"},    err_flags, 0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int out_before, fs_before;
    coords_a = {10'd11, 10'd22, 10'd33, 10'd44, 10'd55, 10'd66, 10'd77, 10'd88};
    coords_b = {10'd210, 10'd403, 10'd422, 10'd639, 10'd479, 10'd2, 10'd210, 10'd314};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Clean frame preceded by three non-SOF beats that must be dropped.
    cfg_coords = coords_a; cfg_wr = 1'b1;
    @(posedge clk); #1;
    cfg_wr = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_beat(24'hBAD000 + 24'(i), 1'b0, 1'b0);
    check("junk_dropped_fs", n_fs, 0);
    out_before = n_out;
    send_frame(W * H, -1, -1, -1, -1);
    drain();
    check("clean_out_beats", n_out - out_before, W * H);
    check("done_timing", fd_cyc, exp_fd_cyc);
    check("clean_err", err_flags, 2'b00);
    check("roi_a", roi_coords, coords_a);

    // Coordinates written mid-frame apply only from the next frame_start.
    send_frame(W * H, -1, -1, 10, -1);
    drain();
    check("roi_hold_end", roi_coords, coords_a);

    // Early SOF at pixel 13: restart, then a full frame from that beat.
    out_before = n_out; fs_before = n_fs;
    send_frame(13 + W * H, 13, -1, -1, -1);
    drain();
    check("roi_b_at_fs", roi_at_fs, coords_b);
    check("early_sof_err", err_flags, 2'b01);
    check("early_sof_beats", n_out - out_before, 13 + W * H);
    check("early_sof_fs", n_fs - fs_before, 2);
    pulse_err_clr();
    check("err_cleared", err_flags, 2'b00);

    // tlast mismatch while err_clr is asserted: the flag must survive.
    send_frame(W * H, -1, 5, -1, -1);
    drain();
    check("tlast_err", err_flags, 2'b10);
    pulse_err_clr();

    // Output back-pressure 1010...
    bp_on = 1'b1;
    out_before = n_out;
    send_frame(W * H, -1, -1, -1, -1);
    drain();
    bp_on = 1'b0;
    check("bp_out_beats", n_out - out_before, W * H);

    // enable dropped at pixel 5: frame completes, then IDLE.
    send_frame(W * H, -1, -1, -1, 5);
    drain();
    s_tvalid = 1'b1; s_tuser = 1'b1;
    @(negedge clk);
    check("idle_tready", s_tready, 0);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tuser = 1'b0;

    // Next frame interrupted by reset.
    enable = 1'b1;
    @(posedge clk); #1;
    send_frame(6, -1, -1, -1, -1);
    #2 aresetn = 1'b0;
    q.delete();
    mdl_wait = 1'b1; mx = 0; my = 0;
    exp_out = n_out;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    check_all_zero("postrst");
    @(posedge clk); #1;
    out_before = n_out;
    send_beat(24'h123456, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("postrst_wait_sof", n_out - out_before, 0);
    send_frame(W * H, -1, -1, -1, -1);
    drain();
    check("postrst_frame_beats", n_out - out_before, W * H);
    check("final_err", err_flags, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/roi_frame_ctrl.md
ROI_FRAME_CTRL -- requirements
Module: roi_frame_ctrl

Interface
REQ-001 The module SHALL have parameter IMAGE_WIDTH, default 640: active pixels per line.
REQ-002 The module SHALL have parameter IMAGE_HEIGHT, default 480: active lines per frame.
REQ-003 The module SHALL have parameter AXIS_TDATA_WIDTH, default 24: pixel width (RGB888).
REQ-004 The module SHALL have parameter COORD_W, default 10: width of each ROI corner coordinate.
REQ-005 The module SHALL have port aclk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port aresetn, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port enable, input, 1 bit: frame acceptance permitted.
REQ-008 The module SHALL have port cfg_coords, input, 8*COORD_W bits: {P4_Y,P4_X,P3_Y,P3_X,P2_Y,P2_X,P1_Y,P1_X}, MSB first.
REQ-009 The module SHALL have port cfg_wr, input, 1 bit: 1-cycle strobe that captures cfg_coords into the shadow register.
REQ-010 The module SHALL have ports s_axis_tdata/tvalid/tready/tuser/tlast, AXI-Stream slave, widths AXIS_TDATA_WIDTH/1/1/1/1: raw video in.
REQ-011 The module SHALL have ports m_axis_tdata/tvalid/tready/tuser/tlast, AXI-Stream master, same widths: regenerated video to the ROI datapath.
REQ-012 The module SHALL have port roi_coords, output, 8*COORD_W bits: active coordinates, stable for a whole frame.
REQ-013 The module SHALL have ports frame_start and frame_done, output, 1 bit each: 1-cycle pulses.
REQ-014 The module SHALL have port err_flags, output, 2 bits: sticky flags, [0]=early SOF, [1]=tlast mismatch.
REQ-015 The module SHALL have port err_clr, input, 1 bit: clears err_flags (and the error counters when present).

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_SOF and ACTIVE; IDLE->WAIT_SOF when enable=1; WAIT_SOF->ACTIVE when an accepted beat has tuser=1; ACTIVE->WAIT_SOF when the last pixel (x=IMAGE_WIDTH-1, y=IMAGE_HEIGHT-1) is accepted and enable=1; ACTIVE->IDLE on that same beat when enable=0.
REQ-017 Deasserting enable mid-frame SHALL NOT abort the frame; the module SHALL complete the frame and then go to IDLE.
REQ-018 In IDLE, s_axis_tready SHALL be 0; in WAIT_SOF it SHALL be 1, with beats having tuser=0 discarded (not forwarded).
REQ-019 Forwarding SHALL go through a one-stage register slice with 1-cycle latency; s_axis_tready SHALL be (!m_axis_tvalid || m_axis_tready) in ACTIVE and for the SOF beat; m_axis_tvalid SHALL NOT drop without a handshake.
REQ-020 Counters x (0..IMAGE_WIDTH-1) and y (0..IMAGE_HEIGHT-1) SHALL advance only on accepted beats; x SHALL wrap to 0 and increment y at IMAGE_WIDTH-1; both SHALL wrap to 0 at frame end.
REQ-021 m_axis_tuser SHALL be 1 only when x=0,y=0, and m_axis_tlast SHALL be 1 only when x=IMAGE_WIDTH-1, both derived from the counters and not from the inputs.
REQ-022 roi_coords SHALL load from the shadow register on acceptance of the SOF beat, only when a cfg_wr has occurred since the previous SOF; cfg_wr and the SOF beat in the same cycle SHALL apply the new value to this frame.
REQ-023 frame_start SHALL pulse in the cycle after the SOF beat is accepted; frame_done SHALL pulse in the cycle after the last pixel is accepted.
REQ-024 A beat with tuser=1 accepted in ACTIVE at (x,y)!=(0,0) SHALL set err_flags[0] and restart the counters with that beat as pixel (0,0), including frame_start and the roi_coords load.
REQ-025 An accepted beat whose s_axis_tlast differs from (x==IMAGE_WIDTH-1) SHALL set err_flags[1] without altering the counters.
REQ-026 err_clr and a new error in the same cycle SHALL leave the flag set.

Reset
REQ-027 On aresetn=0, asynchronously: state=IDLE, x=y=0, all m_axis_* outputs=0, s_axis_tready=0, roi_coords=shadow=0, pending flag=0, frame_start=frame_done=0, err_flags=0.
REQ-028 Reset mid-frame SHALL discard the frame; after release, the module SHALL wait for a fresh tuser.

Configuration
REQ-029 With ROI_CTRL_ERR_CNT_EN defined, the module SHALL add outputs err_sof_cnt[15:0] and err_last_cnt[15:0], each incrementing per error event, saturating at 0xFFFF, cleared by reset or err_clr; without the macro, those ports and counters SHALL be absent and only err_flags SHALL exist.

Verification
REQ-030 Stimulus: IMAGE_WIDTH=8, IMAGE_HEIGHT=4, enable=1, one clean frame with tready=1 -> required response: 32 beats out, tuser on beat 0, tlast on beats 7/15/23/31, frame_done 1 cycle after beat 31, err_flags=00.
REQ-031 Stimulus: 3 beats with tuser=0, then SOF -> required response: the 3 beats are dropped and the first output beat is the SOF data.
REQ-032 Stimulus: cfg_wr with coords {210,403,422,639,479,2,210,314} mid-frame -> required response: roi_coords unchanged until the next frame_start, then equal to the new value.
REQ-033 Stimulus: tuser=1 at pixel 13 -> required response: err_flags[0]=1, output tuser on that beat, then 32 more beats counted from it.
REQ-034 Stimulus: m_axis_tready toggling 1010... -> required response: no beats lost or duplicated and data order preserved.
REQ-035 Stimulus: enable dropped at pixel 5, then aresetn pulsed in the next frame -> required response: the first frame completes and the state goes to IDLE; after the reset, all outputs are 0.
